// File: rtl/mul_iterative_if.sv
// Request/response bundle for the iterative multiplier.
// The master side issues start/a/b; the slave side (the multiplier) returns status and results.
interface mul_iterative_if #(
  parameter int unsigned SIZE = 64
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result_lo;
  logic [SIZE-1:0] result_hi;

  modport master (
    output start, a, b,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, a, b,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/mul_iterative.sv
// Iterative unsigned shift-and-add multiplier producing the low (MUL) and high (UMULH)
// halves of a SIZE x SIZE product, one multiplier bit per cycle.
// Optional build macro: MUL_EARLY_TERM_EN -- leave RUN as soon as the remaining multiplier
// bits are all zero; results are unchanged, only latency shrinks.
module mul_iterative #(
  parameter int unsigned SIZE = 64
) (
  input logic           clk,
  input logic           reset,
  mul_iterative_if.slave bus
);

  localparam int unsigned CntW = $clog2(SIZE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [2*SIZE-1:0] mcand_q;
  logic [2*SIZE-1:0] acc_q;
  logic [SIZE-1:0]   mplier_q;
  logic [CntW-1:0]   count_q;
  logic [SIZE-1:0]   res_lo_q;
  logic [SIZE-1:0]   res_hi_q;

  logic [2*SIZE-1:0] acc_sum;
  logic              load;
  logic              last;

  // Datapath control: accumulate candidate, load request and final-iteration detect.
  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    load    = bus.start && ((state_q == StIdle) || (state_q == StDone));
`ifdef MUL_EARLY_TERM_EN
    // Post-shift multiplier zero means this iteration consumed the highest set bit.
    last    = (count_q == CntW'(SIZE - 1)) || (mplier_q[SIZE-1:1] == '0);
`else
    last    = (count_q == CntW'(SIZE - 1));
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = bus.start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand load, one shift-and-add iteration per RUN cycle, result capture on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else if (load) begin
      mcand_q  <= {{SIZE{1'b0}}, bus.a};
      mplier_q <= bus.b;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (state_q == StRun) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CntW'(1);
      // Capture includes this edge's add, so results land together with DONE.
      if (last) begin
        res_lo_q <= acc_sum[SIZE-1:0];
        res_hi_q <= acc_sum[2*SIZE-1:SIZE];
      end
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    bus.busy      = (state_q == StRun);
    bus.done      = (state_q == StDone);
    bus.result_lo = res_lo_q;
    bus.result_hi = res_hi_q;
  end

endmodule

// File: tb/tb_mul_iterative.sv
// Scoreboard bench for mul_iterative: the driver pushes the expected product and iteration
// count at each accepted request; the monitor pops and compares on every done pulse and
// checks that results hold steady and busy is never seen without an outstanding request.
module tb_mul_iterative;

  localparam int unsigned SIZE = 64;
`ifdef MUL_EARLY_TERM_EN
  localparam int unsigned PulseEdge = 2;
`else
  localparam int unsigned PulseEdge = 10;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mul_iterative_if #(.SIZE(SIZE)) bus ();

  mul_iterative #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [SIZE-1:0] lo;
    logic [SIZE-1:0] hi;
    logic [31:0]     iters;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              vectors     = 0;
  int              miscompares = 0;
  logic [SIZE-1:0] hold_lo     = '0;
  logic [SIZE-1:0] hold_hi     = '0;
  int              busy_cnt    = 0;

  // Number of RUN cycles an operation should take.
  function automatic int iters_of(input logic [SIZE-1:0] b);
    int n;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < int'(SIZE); i++) if (b[i]) n = i + 1;
`else
    n = SIZE;
`endif
    return n;
  endfunction

  function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [2*SIZE-1:0] p;
    exp_t              e;
    p       = (2*SIZE)'(a) * (2*SIZE)'(b);
    e.lo    = p[SIZE-1:0];
    e.hi    = p[2*SIZE-1:SIZE];
    e.iters = 32'(iters_of(b));
    return e;
  endfunction

  task automatic check(input string name, input logic [SIZE-1:0] act,
                       input logic [SIZE-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_lo  = '0;
      hold_hi  = '0;
      busy_cnt = 0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with no request outstanding at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("result_lo", bus.result_lo, mon_e.lo);
        check("result_hi", bus.result_hi, mon_e.hi);
        check("busy_cycles", SIZE'(busy_cnt), SIZE'(mon_e.iters));
        hold_lo = mon_e.lo;
        hold_hi = mon_e.hi;
      end
      busy_cnt = 0;
    end else begin
      check("hold_lo", bus.result_lo, hold_lo);
      check("hold_hi", bus.result_hi, hold_hi);
      if (bus.busy) begin
        busy_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL busy_idle: busy=1 expected 0 with no request at %0t", $time);
        end
      end
    end
  end

  // Present a request that the DUT is known to accept at the next edge.
  task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
  endtask

  // Returns #1 after the edge that raised done, or flags a timeout.
  task automatic wait_done();
    for (int i = 0; i < int'(SIZE) + 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done: done not seen within %0d cycles at %0t", SIZE + 8, $time);
  endtask

  initial begin
    logic [SIZE-1:0] ra, rb;
    int              gap;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle with no request: outputs must stay at zero.
    repeat (100) @(posedge clk);
    #1;
    check("idle_busy", SIZE'(bus.busy), '0);
    check("idle_done", SIZE'(bus.done), '0);

    issue(SIZE'(3), SIZE'(5));
    wait_done();
    issue('1, '1);
    wait_done();
    issue(SIZE'(64'h1234), '0);
    wait_done();

    // Back-to-back: a start pulse while busy is ignored, start held in DONE reloads.
    issue(SIZE'(7), SIZE'(6));
    repeat (PulseEdge - 1) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = SIZE'(9);
    bus.b     = SIZE'(9);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    issue(SIZE'(2), SIZE'(8));
    check("b2b_busy", SIZE'(bus.busy), SIZE'(1));
    wait_done();

    // Reset mid-operation aborts it; nothing may complete afterwards.
    issue(SIZE'(5), SIZE'(5));
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", SIZE'(bus.busy), '0);
    check("rst_lo", bus.result_lo, '0);
    check("rst_hi", bus.result_hi, '0);
    repeat (100) @(posedge clk);
    #1;

    // Random operands, some with short multipliers, random gaps including back-to-back.
    for (int n = 0; n < 30; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, int'(SIZE) - 1);
      if ($urandom_range(0, 9) == 0) ra = '0;
      issue(ra, rb);
      wait_done();
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", SIZE'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
